// File: rtl/regarb_pkg.sv
// +--------------------------------------------------------------------------+
// | regarb_pkg : shared widths and request/stage types for the write arbiter |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package regarb_pkg;

  localparam int REGARB_NUM_REGS = 32;
  localparam int REGARB_IDX_W    = $clog2(REGARB_NUM_REGS);
  localparam int REGARB_DATA_W   = 32;

  typedef struct packed {
    logic [REGARB_IDX_W-1:0]  idx;
    logic [REGARB_DATA_W-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic                     valid;
    logic [REGARB_IDX_W-1:0]  idx;
    logic [REGARB_DATA_W-1:0] data;
  } wr_stage_t;

endpackage : regarb_pkg

`default_nettype wire

// File: rtl/regarb_picker.sv
// +--------------------------------------------------------------------------+
// | regarb_picker : 2-way one-hot grant; REGARB_ROUND_ROBIN_EN selects        |
// |                 round-robin, otherwise fixed priority to requester 0     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module regarb_picker (
  input  logic valid0,
  input  logic valid1,
  input  logic hold,
`ifdef REGARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!hold) begin
      if (valid0 && valid1) begin
`ifdef REGARB_ROUND_ROBIN_EN
        // last_grant=1 means requester 1 won most recently, so 0 goes next
        grant0 = last_grant;
        grant1 = ~last_grant;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

endmodule : regarb_picker

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter : shares the register file write port between two  |
// |   writeback sources via a one-deep write stage with read bypass.         |
// |   Optional macro: REGARB_ROUND_ROBIN_EN (round-robin conflict grant).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter  int NUM_REGS = REGARB_NUM_REGS,
  parameter  int DATA_W   = REGARB_DATA_W,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [IDX_W-1:0]    req0_idx,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [IDX_W-1:0]    req1_idx,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                hold,
  output logic [IDX_W-1:0]    select_w,
  output logic [DATA_W-1:0]   data_write,
  output logic                write,
  input  logic [IDX_W-1:0]    rd_sel_a,
  input  logic [IDX_W-1:0]    rd_sel_b,
  input  logic [DATA_W-1:0]   rf_data_a,
  input  logic [DATA_W-1:0]   rf_data_b,
  output logic [DATA_W-1:0]   byp_data_a,
  output logic [DATA_W-1:0]   byp_data_b,
  output logic [NUM_REGS-1:0] pending_mask
);

  wr_req_t   req0;
  wr_req_t   req1;
  wr_req_t   req_sel;
  wr_stage_t stage;
  logic      grant0;
  logic      grant1;
  logic      block;
  logic      xfer;

  assign req0  = '{idx: req0_idx, data: req0_data};
  assign req1  = '{idx: req1_idx, data: req1_data};

  // Grants must vanish the instant reset asserts, not at the next edge
  assign block = hold | ~rst_n;

`ifdef REGARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant1;
    end
  end

  regarb_picker u_picker (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .hold       (block),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );
`else
  regarb_picker u_picker (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .hold   (block),
    .grant0 (grant0),
    .grant1 (grant1)
  );
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = (req0_valid & grant0) | (req1_valid & grant1);
  assign req_sel    = grant1 ? req1 : req0;

  // The stage drains every cycle; only the valid bit tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage.valid <= xfer;
      if (xfer) begin
        stage.idx  <= req_sel.idx;
        stage.data <= req_sel.data;
      end
    end
  end

  assign write      = stage.valid;
  assign select_w   = stage.idx;
  assign data_write = stage.data;

  assign byp_data_a = (stage.valid && (rd_sel_a == stage.idx)) ? stage.data : rf_data_a;
  assign byp_data_b = (stage.valid && (rd_sel_b == stage.idx)) ? stage.data : rf_data_b;

  always_comb begin
    pending_mask = '0;
    if (stage.valid) begin
      pending_mask[stage.idx] = 1'b1;
    end
  end

endmodule : regfile_write_arbiter

`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32-entry register file between two writeback requesters (ALU result path and load/memory path). Accepts one write per cycle through valid/ready handshakes, registers it in a one-deep write stage that drives the register file write port, and supplies bypassed read data so reads issued during a pending write observe the new value. Sits between the execute/memory writeback sources and the register file.

## Interface
- NUM_REGS, 32: register count; index width IDX_W = $clog2(NUM_REGS)
- DATA_W, 32: data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has a write
- req0_idx / req1_idx  in  IDX_W  destination register
- req0_data / req1_data  in  DATA_W  write data
- req0_ready / req1_ready  out  1  grant; transfer when valid & ready
- hold  in  1  blocks all grants while high
- select_w  out  IDX_W  to register file
- data_write  out  DATA_W  to register file
- write  out  1  to register file
- rd_sel_a / rd_sel_b  in  IDX_W  read indices also sent to register file
- rf_data_a / rf_data_b  in  DATA_W  raw register file read data
- byp_data_a / byp_data_b  out  DATA_W  bypassed read data
- pending_mask  out  NUM_REGS  one-hot of register in write stage

## Operation
- Write stage: valid bit, idx, data. Loaded on any accepted transfer; cleared when no transfer that cycle. Stage drains every cycle (write port never stalls), so acceptance never depends on stage occupancy.
- Grant: at most one ready per cycle; ready is combinational from valids, hold, and arbitration state. hold=1 or rst_n=0 -> both readys 0.
- Only requester valid -> granted. Both valid -> arbitration (see Configuration).
- write = stage valid; select_w/data_write = stage idx/data.
- Bypass: byp_data_x = stage data if stage valid and rd_sel_x == stage idx, else rf_data_x. Combinational.
- pending_mask: bit[stage idx] set iff stage valid; else all zero.
- Writes to index 0 are written like any other register (no hardwired zero).

## Timing
- Reset values: write=0, select_w=0, data_write=0, pending_mask=0, last-grant pointer=1 (so requester 0 wins the first conflict).
- Latency: transfer at edge T -> write=1 during cycle T+1 -> register file updated at edge T+2 boundary (end of T+1). Plain reads correct from cycle T+2; bypass covers cycle T+1.
- Throughput: one write per cycle, back-to-back sustained.
- Same idx from both requesters in consecutive cycles: each issued in order; later one wins in register file.
- Reset mid-operation: stage cleared asynchronously; pending write lost; requesters must re-present.
- hold asserted while stage valid: stage still drains next cycle.
- Valid may drop without a grant; no requester-side state kept.

## Configuration
- REGARB_ROUND_ROBIN_EN defined: 1-bit last-grant pointer; on conflict, grant requester not granted most recently; pointer updates only on an actual transfer.
- Not defined: fixed priority, requester 0 always wins conflicts (load path wired to req0); pointer logic absent.

## Structure
- Package regarb_pkg: IDX_W-derived localparams, typedef wr_req_t {idx, data}, typedef wr_stage_t {valid, idx, data}.
- Sub-module regarb_picker: 2-way arbiter (valids, hold, pointer in -> one-hot grant); holds the REGARB_ROUND_ROBIN_EN ifdef.

## Test plan
- Reset: rst_n low mid-traffic -> write=0, pending_mask=0, readys 0 immediately, without waiting for clk.
- Single write: req0 idx=5 data=0xDEADBEEF at T -> write=1, select_w=5 in T+1; rd_sel_a=5 in T+1 -> byp_data_a=0xDEADBEEF; T+2 register holds value, write=0.
- Conflict: both valid every cycle, req0 idx=1 data=0x11, req1 idx=2 data=0x22 -> with macro grants alternate 0,1,0,1; without macro req0 granted every cycle, req1_ready=0.
- Hold: both valid, hold=1 for 3 cycles -> no readys, stage drains after 1 cycle; hold release -> grant resumes per arbitration.
- Back-to-back same index: req1 idx=7 data=1 then data=2 -> writes on consecutive cycles, final register value 2, bypass returns 1 then 2.
- Bypass miss: stage idx=3, rd_sel_b=4, rf_data_b=0x55 -> byp_data_b=0x55; pending_mask=0x00000008.
